// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the uart_transmitter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                   enable;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   baud_en;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  modport slave (
    input  enable, req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, baud_en, grant_id, busy
  );

  modport master (
    output enable, req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, baud_en, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_transmitter between NUM_REQ byte producers.
// It also generates the transmitter's baud clock_enable and keeps tx_data frozen for
// the whole frame, since the transmitter samples data bits while shifting, not at accept.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CLK_DIV     = 16,
  parameter int FRAME_TICKS = 10
) (
  input  logic              CLKIN,
  input  logic              RESETN,
  uart_tx_arbiter_if.slave  bus
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int TICK_W = $clog2(FRAME_TICKS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  baud_cnt;
  logic              baud_tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              grant;
  logic [7:0]        data_q;
  logic              valid_q;
  logic [ID_W-1:0]   grant_q;

  // Index base+offset, wrapped modulo NUM_REQ (offset never exceeds NUM_REQ).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return sum[ID_W-1:0];
  endfunction

  // Free-running baud divider, independent of arbitration state.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      baud_cnt <= '0;
    end else if (baud_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign baud_tick = (baud_cnt == CNT_W'(CLK_DIV - 1));

  // Round-robin search: first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[wrap_idx(rr_ptr, i)]) begin
        found  = 1'b1;
        winner = wrap_idx(rr_ptr, i);
      end
    end
  end

  assign grant = (state == IDLE) && bus.enable && found;

  // One-hot acceptance pulse in the very cycle the grant is taken; silenced while in reset.
  always_comb begin
    bus.req_ready = '0;
    if (grant && RESETN) begin
      bus.req_ready[winner] = 1'b1;
    end
  end

  // Frame sequencer: grant in IDLE, offer the byte in ARM, hold it for the frame in HOLD.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (grant) state <= ARM;
        ARM:  if (bus.tx_ready) state <= HOLD;
        HOLD: if (baud_tick && (tick_cnt == TICK_W'(FRAME_TICKS - 1))) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the winning byte and owner, and advance priority past the winner.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      data_q  <= '0;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else if (grant) begin
      data_q  <= bus.req_data[8*int'(winner) +: 8];
      grant_q <= winner;
      rr_ptr  <= wrap_idx(winner, 1);
    end
  end

  // Valid is raised with the grant and dropped on the first cycle the transmitter is ready.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      valid_q <= 1'b0;
    end else if (grant) begin
      valid_q <= 1'b1;
    end else if ((state == ARM) && bus.tx_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Count baud ticks of the frame in flight; cleared when the transmitter accepts.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      tick_cnt <= '0;
    end else if ((state == ARM) && bus.tx_ready) begin
      tick_cnt <= '0;
    end else if ((state == HOLD) && baud_tick && (tick_cnt != TICK_W'(FRAME_TICKS - 1))) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign bus.tx_data  = data_q;
  assign bus.tx_valid = valid_q;
  assign bus.grant_id = grant_q;
  assign bus.baud_en  = baud_tick;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-level reference model checked every
// cycle, a simple serial transmitter model, and directed scenarios with literal results.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int CLK_DIV     = 16;
  localparam int FRAME_TICKS = 10;

  logic CLKIN = 1'b0;
  logic RESETN;
  logic stall;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLK_DIV(CLK_DIV),
    .FRAME_TICKS(FRAME_TICKS)
  ) dut (
    .CLKIN(CLKIN),
    .RESETN(RESETN),
    .bus(bus)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transmitter stand-in: accepts on valid&ready, then shifts start, 8 data bits LSB first, stop on baud ticks.
  logic       tx_busy;
  logic [3:0] tx_bit;
  logic [7:0] rx_shift;
  logic       line_q[$];
  logic [7:0] rx_q[$];

  assign bus.tx_ready = !tx_busy && !stall;

  // Serialise the held byte, recording every line bit and every completed byte.
  always @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      tx_busy <= 1'b0;
      tx_bit  <= 4'd0;
    end else if (!tx_busy) begin
      if (bus.tx_valid && bus.tx_ready) begin
        tx_busy <= 1'b1;
        tx_bit  <= 4'd0;
      end
    end else if (bus.baud_en) begin
      tx_bit <= tx_bit + 4'd1;
      if (tx_bit == 4'd0) begin
        line_q.push_back(1'b0);
      end else if (tx_bit <= 4'd8) begin
        rx_shift[tx_bit - 4'd1] <= bus.tx_data[tx_bit - 4'd1];
        line_q.push_back(bus.tx_data[tx_bit - 4'd1]);
      end else begin
        line_q.push_back(1'b1);
        rx_q.push_back(rx_shift);
        tx_busy <= 1'b0;
      end
    end
  end

  // Reference model: frame phases (0 idle, 1 offered, 2 on the wire) and rotating priority.
  int         cyc;
  int         m_phase;
  int         m_ticks;
  int         m_rr;
  int         m_id;
  logic [7:0] m_byte;

  // Compare every DUT output against the model once per cycle, then advance the model.
  always @(negedge CLKIN) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_baud;
    int                 w;
    int                 idx;
    if (!RESETN) begin
      check_output("reset_outputs",
        32'({bus.req_ready, bus.tx_data, bus.tx_valid, bus.baud_en, bus.grant_id, bus.busy}), 32'd0);
      cyc     = 0;
      m_phase = 0;
      m_ticks = 0;
      m_rr    = 0;
      m_id    = 0;
      m_byte  = 8'h00;
    end else begin
      exp_baud  = ((cyc % CLK_DIV) == (CLK_DIV - 1));
      exp_ready = '0;
      w         = -1;
      if (m_phase == 0 && bus.enable) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (w < 0 && bus.req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_output("baud_en",   32'(bus.baud_en),   32'(exp_baud));
      check_output("busy",      32'(bus.busy),      32'(m_phase != 0));
      check_output("tx_valid",  32'(bus.tx_valid),  32'(m_phase == 1));
      check_output("tx_data",   32'(bus.tx_data),   32'(m_byte));
      check_output("grant_id",  32'(bus.grant_id),  32'(m_id));
      if (w >= 0) begin
        m_byte  = bus.req_data[8*w +: 8];
        m_id    = w;
        m_rr    = (w + 1) % NUM_REQ;
        m_phase = 1;
      end else if (m_phase == 1 && bus.tx_ready) begin
        m_phase = 2;
        m_ticks = 0;
      end else if (m_phase == 2 && exp_baud) begin
        m_ticks++;
        if (m_ticks == FRAME_TICKS) m_phase = 0;
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLKIN);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic [NUM_REQ-1:0] valid, input logic [8*NUM_REQ-1:0] data);
    bus.enable    = en;
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    repeat (3) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;
  endtask

  task automatic wait_grant(input string name, input int limit, output int id,
                            output logic [NUM_REQ-1:0] ready, output int waited);
    int n;
    n  = 0;
    id = -1;
    @(negedge CLKIN);
    while (bus.req_ready == '0 && n < limit) begin
      @(negedge CLKIN);
      n++;
    end
    check_output(name, 32'(bus.req_ready != '0), 32'd1);
    ready = bus.req_ready;
    for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) id = k;
    waited = n;
    @(posedge CLKIN);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    @(negedge CLKIN);
    while (bus.busy && n < limit) begin
      @(negedge CLKIN);
      n++;
    end
    check_output(name, 32'(bus.busy), 32'd0);
    @(posedge CLKIN);
    #1;
  endtask

  function automatic logic [7:0] last_rx();
    if (rx_q.size() == 0) return 8'hxx;
    return rx_q[rx_q.size() - 1];
  endfunction

  // Directed scenarios.
  initial begin
    int                 id;
    int                 waited;
    int                 n;
    int                 base;
    int                 lbase;
    logic [NUM_REQ-1:0] ready;
    logic [9:0]         exp_line;
    logic [7:0]         exp_frames [5];
    int                 ids [5];

    stall  = 1'b0;
    apply_stimulus(1'b0, '0, '0);
    RESETN = 1'b1;
    #1 RESETN = 1'b0;
    repeat (3) @(posedge CLKIN);
    #1;
    check_output("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_output("reset_busy",     32'(bus.busy),     32'd0);
    RESETN = 1'b1;

    // First baud tick lands CLK_DIV-1 cycles after release.
    n = 0;
    @(negedge CLKIN);
    while (!bus.baud_en && n < 40) begin
      @(negedge CLKIN);
      n++;
    end
    check_output("first_baud_cycle", 32'(n), 32'(CLK_DIV - 1));
    @(posedge CLKIN);
    #1;

    // Single request from requester 2 with byte 0xA5, dropped right after the grant.
    base  = rx_q.size();
    lbase = line_q.size();
    apply_stimulus(1'b1, 4'b0100, 32'h00A5_0000);
    wait_grant("single_grant", 50, id, ready, waited);
    check_output("single_ready",   32'(ready),  32'h4);
    check_output("single_latency", 32'(waited), 32'd0);
    check_output("single_gid",     32'(bus.grant_id), 32'd2);
    check_output("single_txdata",  32'(bus.tx_data),  32'hA5);
    apply_stimulus(1'b1, 4'b0000, 32'h00A5_0000);
    wait_idle("single_idle", 400);
    exp_line = 10'b11_0100_1010;
    check_output("single_line_len", 32'(line_q.size() - lbase), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("single_line_bit%0d", i),
        32'((lbase + i < line_q.size()) ? line_q[lbase + i] : 1'bx), 32'(exp_line[i]));
    end
    check_output("single_rx_count", 32'(rx_q.size() - base), 32'd1);
    check_output("single_rx_byte",  32'(last_rx()), 32'hA5);

    // All four requesters valid: strictly rotating service starting from requester 0.
    apply_reset();
    base = rx_q.size();
    exp_frames = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    apply_stimulus(1'b1, 4'b1111, 32'h1312_1110);
    for (int f = 0; f < 5; f++) begin
      wait_grant($sformatf("rot_grant%0d", f), 400, ids[f], ready, waited);
      check_output($sformatf("rot_onehot%0d", f), 32'($countones(ready)), 32'd1);
    end
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    wait_idle("rot_idle", 400);
    check_output("rot_rx_count", 32'(rx_q.size() - base), 32'd5);
    for (int f = 0; f < 5; f++) begin
      check_output($sformatf("rot_id%0d", f), 32'(ids[f]), 32'(f % NUM_REQ));
      check_output($sformatf("rot_byte%0d", f),
        32'((base + f < rx_q.size()) ? rx_q[base + f] : 8'hxx), 32'(exp_frames[f]));
    end

    // Priority wrap: after serving requester 3, requesters 1 and 3 compete and 1 wins.
    apply_stimulus(1'b1, 4'b1000, 32'h1312_1110);
    wait_grant("wrap_first", 50, id, ready, waited);
    check_output("wrap_first_id", 32'(id), 32'd3);
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    wait_idle("wrap_idle1", 400);
    apply_stimulus(1'b1, 4'b1010, 32'h1312_1110);
    wait_grant("wrap_second", 50, id, ready, waited);
    check_output("wrap_second_ready", 32'(ready), 32'h2);
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    wait_idle("wrap_idle2", 400);
    check_output("wrap_rx_byte", 32'(last_rx()), 32'h11);

    // Enable dropped mid-frame: the frame finishes, then no grant until enable returns.
    apply_stimulus(1'b1, 4'b0001, 32'h1312_1110);
    wait_grant("en_grant", 50, id, ready, waited);
    check_output("en_grant_id", 32'(id), 32'd0);
    step(40);
    apply_stimulus(1'b0, 4'b0001, 32'h1312_1110);
    wait_idle("en_idle", 400);
    check_output("en_rx_byte", 32'(last_rx()), 32'h10);
    step(100);
    check_output("en_still_idle",  32'(bus.busy),      32'd0);
    check_output("en_no_ready",    32'(bus.req_ready), 32'd0);
    apply_stimulus(1'b1, 4'b0001, 32'h1312_1110);
    wait_grant("en_regrant", 50, id, ready, waited);
    check_output("en_regrant_ready",   32'(ready),  32'h1);
    check_output("en_regrant_latency", 32'(waited), 32'd0);
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    wait_idle("en_idle2", 400);

    // Transmitter not ready: valid is held in ARM until ready appears.
    stall = 1'b1;
    apply_stimulus(1'b1, 4'b0100, 32'h1312_1110);
    wait_grant("stall_grant", 50, id, ready, waited);
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    step(30);
    check_output("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
    check_output("stall_busy",     32'(bus.busy),     32'd1);
    stall = 1'b0;
    wait_idle("stall_idle", 400);
    check_output("stall_rx_byte", 32'(last_rx()), 32'h12);

    // Reset during ARM abandons the frame; requester 0 is served first afterwards.
    stall = 1'b1;
    base  = rx_q.size();
    apply_stimulus(1'b1, 4'b0100, 32'h1312_1110);
    wait_grant("rst_grant", 50, id, ready, waited);
    check_output("rst_grant_id", 32'(id), 32'd2);
    apply_stimulus(1'b1, 4'b0101, 32'h1312_1110);
    step(2);
    check_output("rst_pre_valid", 32'(bus.tx_valid), 32'd1);
    RESETN = 1'b0;
    #1;
    check_output("rst_async_valid", 32'(bus.tx_valid), 32'd0);
    check_output("rst_async_busy",  32'(bus.busy),     32'd0);
    stall = 1'b0;
    step(2);
    RESETN = 1'b1;
    wait_grant("rst_regrant", 50, id, ready, waited);
    check_output("rst_regrant_ready",   32'(ready),  32'h1);
    check_output("rst_regrant_latency", 32'(waited), 32'd0);
    apply_stimulus(1'b1, 4'b0000, 32'h1312_1110);
    wait_idle("rst_idle", 400);
    check_output("rst_rx_count", 32'(rx_q.size() - base), 32'd1);
    check_output("rst_rx_byte",  32'(last_rx()), 32'h10);

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
